clock_set_controller: RTL and testbench
=======================================

# clock_set_controller

Button-driven mode controller that sequences time-setting and alarm-setting for `digital_clock_top`. It captures the running time into edit registers, steps the hour, minute and second fields with wrap-around, and commits the edited time through a one-cycle `load` pulse. It also owns the committed alarm registers and `alarm_en`, and drives the clock's alarm inputs directly. It sits between the debounced front-panel buttons and the clock datapath.

## Interface

Parameters:
- `TIMEOUT`, default 1000: idle `tick` cycles in any set mode before abandoning the edit.
- `BLINK_HALF`, default 50: `tick` cycles per half-period of `blink`.

Ports:
- `tick  in  1`: clock, all logic on posedge.
- `reset  in  1`: synchronous, active-high.
- `btn_mode  in  1`: one-cycle pulse (already debounced); advance to the next field.
- `btn_inc  in  1`: one-cycle pulse; increment the current field.
- `btn_dec  in  1`: one-cycle pulse; decrement the current field.
- `btn_alarm  in  1`: one-cycle pulse; toggle `alarm_en` (RUN only).
- `cur_hour  in  5`, `cur_min  in  6`, `cur_sec  in  6`: live time from the clock.
- `set_hour  out  5`, `set_min  out  6`, `set_sec  out  6`: edit registers; also the load data.
- `load  out  1`: one-cycle pulse; the clock takes `set_*` as its new time.
- `alarm_hour  out  5`, `alarm_min  out  6`, `alarm_sec  out  6`: committed alarm time.
- `alarm_en  out  1`: alarm enable.
- `mode  out  3`: current state encoding.
- `editing  out  1`: high whenever `mode` is not RUN.
- `blink  out  1`: display blink for the active field; held 0 in RUN.

## Operation

- **States and encodings:** RUN=0, T_HOUR=1, T_MIN=2, T_SEC=3, A_HOUR=4, A_MIN=5, A_SEC=6. The value 7 is illegal and recovers to RUN.
- **RUN, `btn_mode`:**
  - Go to T_HOUR.
  - Copy `cur_*` into `set_*` at the same edge.
- **T_HOUR → T_MIN → T_SEC on `btn_mode`:** edit values are retained across these steps.
- **T_SEC, `btn_mode`:**
  - Go to A_HOUR.
  - Assert `load` for exactly one cycle.
  - Copy `alarm_*` into `set_*` at the following edge, after the load cycle, so `set_*` holds the time data throughout `load`.
- **A_HOUR → A_MIN → A_SEC on `btn_mode`:** edit values are retained.
- **A_SEC, `btn_mode`:** copy `set_*` into `alarm_*`, then go to RUN. No `load` pulse.
- **Field arithmetic:**
  - Hour field: `btn_inc` gives 23→0; `btn_dec` gives 0→23.
  - Minute and second fields: modulo 60, so 59→0 and 0→59.
  - Only the field named by the current state changes.
- **Simultaneous buttons:**
  - `btn_mode` has priority; any `btn_inc`/`btn_dec` in the same cycle is dropped.
  - `btn_inc` and `btn_dec` together, without `btn_mode`, is a no-op.
- **`btn_alarm`:**
  - In RUN it toggles `alarm_en`.
  - In set states it is ignored.
  - If `btn_alarm` and `btn_mode` arrive together in RUN, both act.
- **Timeout:**
  - The idle counter clears on entry to any set state and on any button pulse.
  - When it reaches `TIMEOUT-1` in a set state, go to RUN.
  - No `load` is issued and `alarm_*` is not written.
  - A time edit already loaded from T_SEC stays applied.
- **`blink`:**
  - A free counter toggles `blink` every `BLINK_HALF` cycles while `editing`.
  - The counter and `blink` clear on entry to a set state and in RUN.
- **Reset:**
  - `mode`=RUN.
  - `set_*`, `alarm_*`, `alarm_en`, `load`, `blink` and all counters = 0.
  - Reset mid-edit discards the edit and suppresses any pending `load`.

## Timing

- All outputs are registered; button effects are visible one cycle after the sampling edge.
- `load` is high for the single cycle after the edge that samples `btn_mode` in T_SEC. `mode` reads A_HOUR in that same cycle.
- The clock must treat `load` as overriding its own increment in that cycle.
- `alarm_*` updates and `mode`=RUN appear together, one cycle after `btn_mode` in A_SEC.
- The clock keeps counting during an edit; `cur_*` is sampled only at RUN→T_HOUR.
- Back-to-back button pulses on consecutive cycles are each honoured.

## Structure

- **Package `clock_ctrl_pkg`:**
  - State enum `ctrl_mode_t`.
  - Constants `HOUR_MAX`=23, `MIN_MAX`=59, `SEC_MAX`=59.
  - Field widths 5/6/6.
- **Sub-module `field_step`:**
  - Parameterised by MAX and width.
  - Inputs: value, inc, dec.
  - Output: wrapped next value.
  - Instantiated three times.
- **Top:** FSM, edit/alarm registers, idle counter, blink counter.

## Test plan

- **Capture and hold:** reset, run the clock to 0:0:7, pulse `btn_mode` → `mode`=1 and `set_*`=0:0:7. With no further input, `set_*` is unchanged for 20 cycles.
- **Hour wrap:** in T_HOUR with `set_hour`=23, pulse `btn_inc` → 0; pulse `btn_dec` → 23. In T_MIN at 0, `btn_dec` → 59.
- **Time commit:** edit to 5:30:10, step through T_SEC → exactly one `load` cycle with `set_*`=5:30:10. The clock then shows 5:30:10, followed by 5:30:11.
- **Alarm commit:** in A_* set 0:0:20, press `btn_mode` at A_SEC → `alarm_*`=0:0:20 and `mode`=0. Then `btn_alarm` → `alarm_en`=1, and `alarm_out` fires at 0:0:20.
- **Timeout with `TIMEOUT`=16:** enter T_MIN, press `btn_inc` twice, then idle 16 cycles → `mode`=0, no `load`, clock time unaffected.
- **Corner cases:**
  - `btn_mode` and `btn_inc` together in T_HOUR → advance only, `set_hour` unchanged.
  - `reset` in A_MIN → all outputs 0, `mode`=0.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock time/alarm setting controller.
// Field widths and wrap limits match the digital_clock_top datapath.
package clock_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    T_HOUR = 3'd1,
    T_MIN  = 3'd2,
    T_SEC  = 3'd3,
    A_HOUR = 3'd4,
    A_MIN  = 3'd5,
    A_SEC  = 3'd6
  } ctrl_mode_t;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  localparam logic [1:0] FLD_HOUR = 2'd0;
  localparam logic [1:0] FLD_MIN  = 2'd1;
  localparam logic [1:0] FLD_SEC  = 2'd2;
  localparam logic [1:0] FLD_NONE = 2'd3;

  // Which edit field a mode addresses; time and alarm modes share fields.
  function automatic logic [1:0] field_of(input logic [2:0] m);
    case (m)
      T_HOUR, A_HOUR: return FLD_HOUR;
      T_MIN,  A_MIN:  return FLD_MIN;
      T_SEC,  A_SEC:  return FLD_SEC;
      default:        return FLD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/field_step.sv
// One time field stepped up or down by one with wrap-around at MAX.
// Both or neither direction requested leaves the value unchanged.
module field_step #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic [W-1:0] value,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] next_value
);

  always_comb begin
    next_value = value;
    if (inc && !dec) begin
      next_value = (value >= W'(MAX)) ? '0 : value + W'(1);
    end else if (dec && !inc) begin
      next_value = (value == '0 || value > W'(MAX)) ? W'(MAX) : value - W'(1);
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Front-panel mode controller: edits the running time and the alarm time,
// commits time edits with a one-cycle load pulse and owns the alarm registers.
module clock_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int TIMEOUT    = 1000,
  parameter int BLINK_HALF = 50
) (
  input  logic              tick,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic              btn_alarm,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [SEC_W-1:0]  cur_sec,
  output logic [HOUR_W-1:0] set_hour,
  output logic [MIN_W-1:0]  set_min,
  output logic [SEC_W-1:0]  set_sec,
  output logic              load,
  output logic [HOUR_W-1:0] alarm_hour,
  output logic [MIN_W-1:0]  alarm_min,
  output logic [SEC_W-1:0]  alarm_sec,
  output logic              alarm_en,
  output logic [2:0]        mode,
  output logic              editing,
  output logic              blink
);

  localparam logic [2:0] ST_RUN    = RUN;
  localparam logic [2:0] ST_T_HOUR = T_HOUR;
  localparam logic [2:0] ST_T_MIN  = T_MIN;
  localparam logic [2:0] ST_T_SEC  = T_SEC;
  localparam logic [2:0] ST_A_HOUR = A_HOUR;
  localparam logic [2:0] ST_A_MIN  = A_MIN;
  localparam logic [2:0] ST_A_SEC  = A_SEC;

  localparam int IDLE_W  = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [2:0]         mode_q;
  logic [2:0]         mode_d;
  logic               load_d;
  logic               commit_alarm;
  logic               any_btn;
  logic               timed_out;
  logic [1:0]         fsel;
  logic               step_inc;
  logic               step_dec;
  logic [HOUR_W-1:0]  hour_base;
  logic [MIN_W-1:0]   min_base;
  logic [SEC_W-1:0]   sec_base;
  logic [HOUR_W-1:0]  hour_next;
  logic [MIN_W-1:0]   min_next;
  logic [SEC_W-1:0]   sec_next;
  logic [IDLE_W-1:0]  idle_q;
  logic [BLINK_W-1:0] blink_cnt_q;

  assign mode    = mode_q;
  assign editing = (mode_q != ST_RUN);
  assign any_btn = btn_mode | btn_inc | btn_dec | btn_alarm;
  assign fsel    = field_of(mode_q);

  // Mode has priority: a step requested alongside it is dropped.
  assign step_inc = btn_inc & ~btn_mode;
  assign step_dec = btn_dec & ~btn_mode;

  assign timed_out = (mode_q != ST_RUN) && !any_btn &&
                     (idle_q == IDLE_W'(TIMEOUT - 1));

  // During the load cycle set_* still carries the committed time, so edits in
  // A_HOUR that cycle start from the alarm registers being copied in.
  assign hour_base = load ? alarm_hour : set_hour;
  assign min_base  = load ? alarm_min  : set_min;
  assign sec_base  = load ? alarm_sec  : set_sec;

  field_step #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour_step (
    .value      (hour_base),
    .inc        (step_inc & (fsel == FLD_HOUR)),
    .dec        (step_dec & (fsel == FLD_HOUR)),
    .next_value (hour_next)
  );

  field_step #(.W(MIN_W), .MAX(MIN_MAX)) u_min_step (
    .value      (min_base),
    .inc        (step_inc & (fsel == FLD_MIN)),
    .dec        (step_dec & (fsel == FLD_MIN)),
    .next_value (min_next)
  );

  field_step #(.W(SEC_W), .MAX(SEC_MAX)) u_sec_step (
    .value      (sec_base),
    .inc        (step_inc & (fsel == FLD_SEC)),
    .dec        (step_dec & (fsel == FLD_SEC)),
    .next_value (sec_next)
  );

  always_comb begin
    mode_d       = mode_q;
    load_d       = 1'b0;
    commit_alarm = 1'b0;
    case (mode_q)
      ST_RUN:    if (btn_mode) mode_d = ST_T_HOUR;
      ST_T_HOUR: if (btn_mode) mode_d = ST_T_MIN;
      ST_T_MIN:  if (btn_mode) mode_d = ST_T_SEC;
      ST_T_SEC: begin
        if (btn_mode) begin
          mode_d = ST_A_HOUR;
          load_d = 1'b1;
        end
      end
      ST_A_HOUR: if (btn_mode) mode_d = ST_A_MIN;
      ST_A_MIN:  if (btn_mode) mode_d = ST_A_SEC;
      ST_A_SEC: begin
        if (btn_mode) begin
          mode_d       = ST_RUN;
          commit_alarm = 1'b1;
        end
      end
      default:   mode_d = ST_RUN;
    endcase
    if (timed_out) mode_d = ST_RUN;
  end

  always_ff @(posedge tick) begin
    if (reset) begin
      mode_q      <= ST_RUN;
      load        <= 1'b0;
      set_hour    <= '0;
      set_min     <= '0;
      set_sec     <= '0;
      alarm_hour  <= '0;
      alarm_min   <= '0;
      alarm_sec   <= '0;
      alarm_en    <= 1'b0;
      idle_q      <= '0;
      blink_cnt_q <= '0;
      blink       <= 1'b0;
    end else begin
      mode_q <= mode_d;
      load   <= load_d;

      // The live time is captured only when an edit begins.
      if (mode_q == ST_RUN) begin
        if (btn_mode) begin
          set_hour <= cur_hour;
          set_min  <= cur_min;
          set_sec  <= cur_sec;
        end
      end else begin
        set_hour <= hour_next;
        set_min  <= min_next;
        set_sec  <= sec_next;
      end

      if (commit_alarm) begin
        alarm_hour <= set_hour;
        alarm_min  <= set_min;
        alarm_sec  <= set_sec;
      end

      if (btn_alarm && mode_q == ST_RUN) alarm_en <= ~alarm_en;

      if (mode_d != mode_q || mode_q == ST_RUN || any_btn) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + IDLE_W'(1);
      end

      if (mode_d != mode_q || mode_d == ST_RUN) begin
        blink_cnt_q <= '0;
        blink       <= 1'b0;
      end else if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
        blink_cnt_q <= '0;
        blink       <= ~blink;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: a simple seconds-per-tick clock drives cur_*,
// a field-level reference model is compared against every output each cycle.
module tb_clock_set_controller;

  localparam int TMO = 16;
  localparam int BH  = 4;

  logic       tick = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, btn_dec, btn_alarm;
  logic [4:0] cur_hour;
  logic [5:0] cur_min, cur_sec;
  logic [4:0] set_hour, alarm_hour;
  logic [5:0] set_min, set_sec, alarm_min, alarm_sec;
  logic       load, alarm_en, editing, blink;
  logic [2:0] mode;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model state: mode number, fields as plain integers.
  int m_mode, m_idle, m_bcnt;
  int m_set[3];
  int m_alarm[3];
  int lim[3] = '{24, 60, 60};
  bit m_load, m_en, m_blink;

  clock_set_controller #(.TIMEOUT(TMO), .BLINK_HALF(BH)) dut (
    .tick       (tick),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .btn_alarm  (btn_alarm),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .set_hour   (set_hour),
    .set_min    (set_min),
    .set_sec    (set_sec),
    .load       (load),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_sec  (alarm_sec),
    .alarm_en   (alarm_en),
    .mode       (mode),
    .editing    (editing),
    .blink      (blink)
  );

  initial forever #5 tick = ~tick;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_field(input int f);
    case (f)
      0:       return int'(set_hour);
      1:       return int'(set_min);
      default: return int'(set_sec);
    endcase
  endfunction

  function automatic int time_secs();
    return int'(cur_hour) * 3600 + int'(cur_min) * 60 + int'(cur_sec);
  endfunction

  // Reference model, advanced on every rising edge from the sampled inputs.
  initial begin
    int nm, f;
    bit anyb;
    forever begin
      @(posedge tick);
      if (reset) begin
        m_mode = 0; m_idle = 0; m_bcnt = 0;
        m_set = '{0, 0, 0}; m_alarm = '{0, 0, 0};
        m_load = 0; m_en = 0; m_blink = 0;
      end else begin
        if (m_load) m_set = m_alarm;
        m_load = 0;
        anyb = btn_mode | btn_inc | btn_dec | btn_alarm;
        nm = m_mode;
        if (m_mode == 0) begin
          if (btn_alarm) m_en = !m_en;
          if (btn_mode) begin
            nm = 1;
            m_set = '{int'(cur_hour), int'(cur_min), int'(cur_sec)};
          end
        end else if (btn_mode) begin
          nm = (m_mode == 6) ? 0 : m_mode + 1;
          if (m_mode == 3) m_load = 1;
          if (m_mode == 6) m_alarm = m_set;
        end else if (anyb) begin
          f = (m_mode - 1) % 3;
          if (btn_inc && !btn_dec) m_set[f] = (m_set[f] + 1) % lim[f];
          if (btn_dec && !btn_inc) m_set[f] = (m_set[f] + lim[f] - 1) % lim[f];
        end else if (m_idle == TMO - 1) begin
          nm = 0;
        end
        m_idle = (nm != m_mode || nm == 0 || anyb) ? 0 : m_idle + 1;
        if (nm != m_mode || nm == 0) begin
          m_bcnt = 0;
          m_blink = 0;
        end else begin
          m_bcnt++;
          if (m_bcnt == BH) begin
            m_bcnt = 0;
            m_blink = !m_blink;
          end
        end
        m_mode = nm;
      end
    end
  end

  // Compare on the falling edge, then advance the clock datapath stand-in.
  initial forever begin
    @(negedge tick);
    if (chk_en) begin
      chk("mode", mode, m_mode);
      chk("editing", editing, (m_mode != 0) ? 1 : 0);
      chk("load", load, int'(m_load));
      chk("set_hour", set_hour, m_set[0]);
      chk("set_min", set_min, m_set[1]);
      chk("set_sec", set_sec, m_set[2]);
      chk("alarm_hour", alarm_hour, m_alarm[0]);
      chk("alarm_min", alarm_min, m_alarm[1]);
      chk("alarm_sec", alarm_sec, m_alarm[2]);
      chk("alarm_en", alarm_en, int'(m_en));
      chk("blink", blink, int'(m_blink));
    end
    if (reset) begin
      cur_hour = '0; cur_min = '0; cur_sec = '0;
    end else if (load) begin
      cur_hour = set_hour; cur_min = set_min; cur_sec = set_sec;
    end else if (cur_sec == 6'd59) begin
      cur_sec = '0;
      if (cur_min == 6'd59) begin
        cur_min  = '0;
        cur_hour = (cur_hour == 5'd23) ? 5'd0 : cur_hour + 5'd1;
      end else begin
        cur_min = cur_min + 6'd1;
      end
    end else begin
      cur_sec = cur_sec + 6'd1;
    end
  end

  task automatic press(input logic m, input logic i, input logic d, input logic a);
    btn_mode = m; btn_inc = i; btn_dec = d; btn_alarm = a;
    @(posedge tick); #1;
    btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_alarm = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge tick); #1; end
  endtask

  task automatic dial(input int f, input int target);
    int n = 0;
    while (m_set[f] != target && n < 70) begin
      press(0, 1, 0, 0);
      n++;
    end
    chk("dial_field", dut_field(f), target);
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, "_hour"}, cur_hour, h);
    chk({name, "_min"}, cur_min, m);
    chk({name, "_sec"}, cur_sec, s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0;
    bit seen;
    reset = 1; btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_alarm = 0;
    cur_hour = '0; cur_min = '0; cur_sec = '0;
    @(posedge tick); #1;
    chk_en = 1;
    @(posedge tick); #1;
    reset = 0;
    chk("rst_mode", mode, 0);
    chk("rst_set_sec", set_sec, 0);
    chk("rst_alarm_en", alarm_en, 0);
    chk("rst_load", load, 0);

    // The clock steps before the next sampling edge, so 0:0:6 here is sampled as 0:0:7.
    n = 0;
    while (!(cur_hour == 0 && cur_min == 0 && cur_sec == 6) && n < 100) begin
      idle(1);
      n++;
    end
    press(1, 0, 0, 0);
    chk("cap_mode", mode, 1);
    chk("cap_sec", set_sec, 7);
    chk("cap_editing", editing, 1);
    idle(12);
    chk("hold_mode", mode, 1);
    chk("hold_sec", set_sec, 7);
    chk("hold_blink", blink, 1);

    press(0, 0, 1, 0); chk("hour_dec_wrap", set_hour, 23);
    press(0, 1, 0, 0); chk("hour_inc_wrap", set_hour, 0);
    press(0, 0, 1, 0); chk("hour_dec_again", set_hour, 23);
    repeat (6) press(0, 1, 0, 0);
    press(1, 1, 0, 0);
    chk("mode_inc_mode", mode, 2);
    chk("mode_inc_hour", set_hour, 5);
    press(0, 0, 1, 0); chk("min_dec_wrap", set_min, 59);
    press(0, 1, 0, 0);
    press(0, 1, 1, 0); chk("inc_dec_noop", set_min, 0);
    repeat (30) press(0, 1, 0, 0);
    chk("min_30", set_min, 30);
    press(1, 0, 0, 0);
    repeat (3) press(0, 1, 0, 0);
    chk("sec_10", set_sec, 10);

    press(1, 0, 0, 0);
    chk("commit_load", load, 1);
    chk("commit_mode", mode, 4);
    chk("commit_hour", set_hour, 5);
    chk("commit_min", set_min, 30);
    chk("commit_sec", set_sec, 10);
    @(negedge tick); #1;
    chk_time("clk_loaded", 5, 30, 10);
    @(posedge tick); #1;
    chk("load_once", load, 0);
    chk("alarm_copy_sec", set_sec, 0);
    @(negedge tick); #1;
    chk_time("clk_next", 5, 30, 11);

    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    repeat (20) press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    chk("alarm_mode", mode, 0);
    chk("alarm_hour", alarm_hour, 0);
    chk("alarm_min", alarm_min, 0);
    chk("alarm_sec", alarm_sec, 20);
    press(0, 0, 0, 1);
    chk("alarm_en_on", alarm_en, 1);

    // Move the clock to 23:59:55 so the alarm at 0:0:20 comes round shortly.
    press(1, 0, 0, 0);
    press(0, 0, 0, 1);
    chk("alarm_btn_ignored", alarm_en, 1);
    dial(0, 23);
    press(1, 0, 0, 0);
    dial(1, 59);
    press(1, 0, 0, 0);
    dial(2, 55);
    press(1, 0, 0, 0);
    chk("commit2_load", load, 1);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    chk("commit2_mode", mode, 0);
    chk("alarm_kept_sec", alarm_sec, 20);
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge tick); #1;
      if (cur_hour == 0 && cur_min == 0 && cur_sec == 19)
        chk("alarm_out_before", (alarm_en && cur_hour == alarm_hour &&
            cur_min == alarm_min && cur_sec == alarm_sec) ? 1 : 0, 0);
      if (cur_hour == 0 && cur_min == 0 && cur_sec == 20) begin
        chk("alarm_out_fire", (alarm_en && cur_hour == alarm_hour &&
            cur_min == alarm_min && cur_sec == alarm_sec) ? 1 : 0, 1);
        seen = 1;
      end
    end
    if (!seen) chk("alarm_time_reached", 0, 1);

    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    t0 = time_secs();
    idle(TMO - 1);
    chk("tmo_not_yet", mode, 2);
    idle(1);
    chk("tmo_mode", mode, 0);
    chk("tmo_no_load", load, 0);
    chk("tmo_clock", time_secs(), (t0 + TMO) % 86400);

    repeat (5) press(1, 0, 0, 0);
    chk("pre_reset_mode", mode, 5);
    reset = 1;
    @(posedge tick); #1;
    chk("rst2_mode", mode, 0);
    chk("rst2_editing", editing, 0);
    chk("rst2_load", load, 0);
    chk("rst2_blink", blink, 0);
    chk("rst2_alarm_en", alarm_en, 0);
    chk("rst2_set", {set_hour, set_min, set_sec}, 0);
    chk("rst2_alarm", {alarm_hour, alarm_min, alarm_sec}, 0);
    reset = 0;
    idle(2);
    chk("post_reset_mode", mode, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
